axi4_slave_read_addr: RTL and testbench

AXI4 slave read-address (AR) channel front end. Accepts AR handshakes from the master into a small command queue and checks each request for protocol legality. Presents one latched, stable command at a time to the downstream read-data stage, which consumes it with a valid/ready handshake. Decouples AR acceptance from R-channel progress, so the master can post up to FIFO_DEPTH reads ahead.

---
 rtl/axi4_slave_read_addr.sv | 123 ++++++++++++
 tb/tb_axi4_slave_read_addr.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_read_addr.sv
// AXI4 slave AR-channel front end: legality check at accept time, FIFO command queue, one stable head command.
// Optional 4 KB-crossing / WRAP-length checking is compiled in with `define AXI4_AR_BOUNDARY_CHECK_EN.
module axi4_slave_read_addr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ID_WIDTH-1:0]             arid,
  input  logic [ADDR_WIDTH-1:0]           araddr,
  input  logic [7:0]                      arlen,
  input  logic [2:0]                      arsize,
  input  logic [1:0]                      arburst,
  input  logic                            arvalid,
  output logic                            arready,
  output logic [ID_WIDTH-1:0]             latched_arid,
  output logic [ADDR_WIDTH-1:0]           latched_araddr,
  output logic [7:0]                      latched_arlen,
  output logic [2:0]                      latched_arsize,
  output logic [1:0]                      latched_arburst,
  output logic                            latched_arerr,
  output logic                            ar_cmd_valid,
  input  logic                            ar_cmd_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] ar_fifo_count
);

  localparam int         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  err;
  } cmd_t;

  cmd_t             mem [FIFO_DEPTH];
  cmd_t             wr_cmd;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             err;

  assign arready      = (count != CNT_W'(FIFO_DEPTH)) && rst;
  assign ar_cmd_valid = (count != '0);
  assign push         = arvalid && arready;
  assign pop          = ar_cmd_valid && ar_cmd_ready;

`ifdef AXI4_AR_BOUNDARY_CHECK_EN
  // Wide enough for 4095 + 256 beats * 128 bytes without truncation.
  logic [19:0] burst_bytes;
  logic [19:0] burst_end;
  logic        wrap_len_bad;
  logic        crosses_4k;

  always_comb begin
    burst_bytes  = ({12'd0, arlen} + 20'd1) << arsize;
    burst_end    = {8'd0, araddr[11:0]} + burst_bytes;
    crosses_4k   = (arburst == 2'b01) && (burst_end > 20'd4096);
    wrap_len_bad = 1'b0;
    if (arburst == 2'b10) begin
      case (arlen)
        8'd1, 8'd3, 8'd7, 8'd15: wrap_len_bad = 1'b0;
        default:                 wrap_len_bad = 1'b1;
      endcase
    end
  end

  assign err = (arsize > MAX_SIZE) || (arburst == 2'b11) || wrap_len_bad || crosses_4k;
`else
  assign err = (arsize > MAX_SIZE) || (arburst == 2'b11);
`endif

  always_comb begin
    wr_cmd       = '0;
    wr_cmd.id    = arid;
    wr_cmd.addr  = araddr;
    wr_cmd.len   = arlen;
    wr_cmd.size  = arsize;
    wr_cmd.burst = arburst;
    wr_cmd.err   = err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; stale entries are never visible because outputs are gated by ar_cmd_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_cmd;
  end

  assign head = ar_cmd_valid ? mem[rd_ptr] : '0;

  assign latched_arid    = head.id;
  assign latched_araddr  = head.addr;
  assign latched_arlen   = head.len;
  assign latched_arsize  = head.size;
  assign latched_arburst = head.burst;
  assign latched_arerr   = head.err;
  assign ar_fifo_count   = count;

endmodule

// File: tb/tb_axi4_slave_read_addr.sv
// Directed self-checking bench for axi4_slave_read_addr (default parameters, DATA_WIDTH=32, FIFO_DEPTH=2).
module tb_axi4_slave_read_addr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  latched_arid;
  logic [31:0] latched_araddr;
  logic [7:0]  latched_arlen;
  logic [2:0]  latched_arsize;
  logic [1:0]  latched_arburst;
  logic        latched_arerr;
  logic        ar_cmd_valid;
  logic        ar_cmd_ready = 1'b0;
  logic [1:0]  ar_fifo_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef AXI4_AR_BOUNDARY_CHECK_EN
  localparam logic BOUND_ERR = 1'b1;
`else
  localparam logic BOUND_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  axi4_slave_read_addr dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .latched_arid(latched_arid), .latched_araddr(latched_araddr), .latched_arlen(latched_arlen),
    .latched_arsize(latched_arsize), .latched_arburst(latched_arburst), .latched_arerr(latched_arerr),
    .ar_cmd_valid(ar_cmd_valid), .ar_cmd_ready(ar_cmd_ready), .ar_fifo_count(ar_fifo_count)
  );

  // Stimulus helpers start and end at a falling edge.
  task automatic push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic pop();
    ar_cmd_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ar_cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({arready, ar_cmd_valid, ar_fifo_count, latched_araddr, latched_arerr} !== 36'd0)
      $display("FAIL reset_state: arready=%0b valid=%0b count=%0d addr=%h err=%0b required all 0",
               arready, ar_cmd_valid, ar_fifo_count, latched_araddr, latched_arerr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (arready !== 1'b1) $display("FAIL reset_release_arready: got %0b required 1", arready);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_single();
    push(4'd3, 32'h100, 8'd3, 3'd2, 2'b01);
    total_cnt++;
    if ({ar_cmd_valid, latched_arid, latched_araddr, latched_arlen, latched_arsize,
         latched_arburst, latched_arerr, ar_fifo_count} !== {1'b1, 4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 2'd1})
      $display("FAIL single_push: valid=%0b id=%0d addr=%h len=%0d size=%0d burst=%b err=%0b count=%0d required 1/3/100/3/2/01/0/1",
               ar_cmd_valid, latched_arid, latched_araddr, latched_arlen, latched_arsize,
               latched_arburst, latched_arerr, ar_fifo_count);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({ar_cmd_valid, latched_arid, latched_araddr, ar_fifo_count} !== {1'b1, 4'd3, 32'h100, 2'd1})
        $display("FAIL single_hold_%0d: valid=%0b id=%0d addr=%h count=%0d required 1/3/100/1",
                 i, ar_cmd_valid, latched_arid, latched_araddr, ar_fifo_count);
      else pass_cnt++;
    end
    pop();
    total_cnt++;
    if ({ar_cmd_valid, latched_araddr, ar_fifo_count, arready} !== {1'b0, 32'h0, 2'd0, 1'b1})
      $display("FAIL single_empty: valid=%0b addr=%h count=%0d arready=%0b required 0/0/0/1",
               ar_cmd_valid, latched_araddr, ar_fifo_count, arready);
    else pass_cnt++;
  endtask

  task automatic test_full();
    push(4'd1, 32'h200, 8'd0, 3'd2, 2'b01);
    push(4'd2, 32'h300, 8'd0, 3'd2, 2'b01);
    total_cnt++;
    if ({arready, ar_fifo_count, latched_arid} !== {1'b0, 2'd2, 4'd1})
      $display("FAIL full_state: arready=%0b count=%0d id=%0d required 0/2/1",
               arready, ar_fifo_count, latched_arid);
    else pass_cnt++;
    // Pop while full with a pending push: the push must not be taken this cycle.
    arid = 4'd9; araddr = 32'h900; arvalid = 1'b1;
    pop();
    arvalid = 1'b0;
    total_cnt++;
    if ({arready, latched_arid, latched_araddr, ar_fifo_count} !== {1'b1, 4'd2, 32'h300, 2'd1})
      $display("FAIL full_pop: arready=%0b id=%0d addr=%h count=%0d required 1/2/300/1",
               arready, latched_arid, latched_araddr, ar_fifo_count);
    else pass_cnt++;
    pop();
    total_cnt++;
    if ({ar_cmd_valid, ar_fifo_count} !== {1'b0, 2'd0})
      $display("FAIL full_drain: valid=%0b count=%0d required 0/0 (blocked push leaked?)",
               ar_cmd_valid, ar_fifo_count);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    int bad  = 0;
    ar_cmd_ready = 1'b1;
    arid = 4'd0; araddr = 32'h0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    while (recv < 10 && cyc < 60) begin
      #1;
      if (ar_fifo_count > 2'd2) bad++;
      if (ar_cmd_valid) begin
        total_cnt++;
        if (latched_arid !== 4'(recv))
          $display("FAIL b2b_order_%0d: id=%0d required %0d", recv, latched_arid, recv);
        else pass_cnt++;
        recv++;
      end
      if (arvalid && arready) sent++;
      @(posedge clk); @(negedge clk);
      arid = 4'(sent);
      araddr = 32'(sent) << 4;
      arvalid = (sent < 10);
      cyc++;
    end
    arvalid = 1'b0;
    ar_cmd_ready = 1'b0;
    total_cnt++;
    if (recv !== 10 || sent !== 10 || bad !== 0)
      $display("FAIL b2b_totals: received=%0d sent=%0d overcount_cycles=%0d required 10/10/0", recv, sent, bad);
    else pass_cnt++;
    total_cnt++;
    if ({ar_cmd_valid, ar_fifo_count} !== {1'b0, 2'd0})
      $display("FAIL b2b_empty: valid=%0b count=%0d required 0/0", ar_cmd_valid, ar_fifo_count);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    push(4'd5, 32'h40, 8'd0, 3'd3, 2'b01);
    push(4'd6, 32'h80, 8'd0, 3'd2, 2'b11);
    total_cnt++;
    if ({latched_arid, latched_arerr, latched_arsize} !== {4'd5, 1'b1, 3'd3})
      $display("FAIL err_size: id=%0d err=%0b size=%0d required 5/1/3", latched_arid, latched_arerr, latched_arsize);
    else pass_cnt++;
    pop();
    push(4'd7, 32'h0, 8'd7, 3'd2, 2'b10);
    total_cnt++;
    if ({latched_arid, latched_arerr, latched_arburst} !== {4'd6, 1'b1, 2'b11})
      $display("FAIL err_burst: id=%0d err=%0b burst=%b required 6/1/11", latched_arid, latched_arerr, latched_arburst);
    else pass_cnt++;
    pop();
    total_cnt++;
    if ({latched_arid, latched_arerr} !== {4'd7, 1'b0})
      $display("FAIL err_legal_wrap: id=%0d err=%0b required 7/0", latched_arid, latched_arerr);
    else pass_cnt++;
    pop();
  endtask

  task automatic test_boundary();
    push(4'd1, 32'hFF8, 8'd3, 3'd2, 2'b01);
    total_cnt++;
    if ({latched_arid, latched_arerr} !== {4'd1, BOUND_ERR})
      $display("FAIL bound_cross: id=%0d err=%0b required 1/%0b", latched_arid, latched_arerr, BOUND_ERR);
    else pass_cnt++;
    pop();
    push(4'd2, 32'h0, 8'd2, 3'd2, 2'b10);
    total_cnt++;
    if ({latched_arid, latched_arerr} !== {4'd2, BOUND_ERR})
      $display("FAIL bound_wrap_len: id=%0d err=%0b required 2/%0b", latched_arid, latched_arerr, BOUND_ERR);
    else pass_cnt++;
    pop();
    // Ends exactly on the 4 KB line: legal in both builds.
    push(4'd3, 32'hFF0, 8'd3, 3'd2, 2'b01);
    total_cnt++;
    if ({latched_arid, latched_arerr} !== {4'd3, 1'b0})
      $display("FAIL bound_exact: id=%0d err=%0b required 3/0", latched_arid, latched_arerr);
    else pass_cnt++;
    pop();
  endtask

  task automatic test_reset_midflight();
    push(4'd10, 32'hA00, 8'd1, 3'd1, 2'b01);
    push(4'd11, 32'hB00, 8'd1, 3'd1, 2'b01);
    total_cnt++;
    if (ar_fifo_count !== 2'd2) $display("FAIL mid_prefill: count=%0d required 2", ar_fifo_count);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({ar_cmd_valid, latched_arid, latched_araddr, latched_arlen, latched_arsize, ar_fifo_count, arready} !== '0)
      $display("FAIL mid_reset: valid=%0b id=%0d addr=%h len=%0d size=%0d count=%0d arready=%0b required all 0",
               ar_cmd_valid, latched_arid, latched_araddr, latched_arlen, latched_arsize, ar_fifo_count, arready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({arready, ar_cmd_valid, ar_fifo_count} !== {1'b1, 1'b0, 2'd0})
      $display("FAIL mid_release: arready=%0b valid=%0b count=%0d required 1/0/0", arready, ar_cmd_valid, ar_fifo_count);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_errors();
    test_boundary();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
